// File: rtl/serial_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_scheduler
// Brief    : Two-requester round-robin front end around a single one-bit
//            full-adder slice. Each W-bit add is evaluated LSB first, one
//            bit per clock, with carry feedback. Results are tagged with
//            the id of the requester that owns them.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_scheduler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_id
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_ptr;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_c;
  logic             r_cout;
  logic             r_id;
  logic [CNT_W-1:0] r_cnt;

  logic w_grant0;
  logic w_grant1;
  logic w_hs;
  logic w_last;
  logic w_abit;
  logic w_bbit;
  logic w_sbit;
  logic w_cnext;

  // Round-robin grant; only offered in IDLE and never while reset is asserted.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == IDLE && reset) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = ~r_ptr;
        w_grant1 = r_ptr;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign w_hs       = w_grant0 | w_grant1;

  // The operand registers shift right each RUN cycle, so bit 0 is always
  // the bit currently being added; this keeps W=1 free of index corner cases.
  assign w_abit  = r_a[0];
  assign w_bbit  = r_b[0];
  assign w_sbit  = w_abit ^ w_bbit ^ r_c;
  assign w_cnext = (w_abit & w_bbit) | (r_c & (w_abit ^ w_bbit));
  assign w_last  = (r_cnt == CNT_W'(W - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and result-valid decode.
  always_comb begin
    w_state_next = r_state;
    res_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture on handshake, then one full-adder step per RUN cycle.
  // Sum bits enter at the MSB and shift down, landing in place after W steps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr  <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_id   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_hs) begin
      r_a   <= w_grant1 ? req1_a : req0_a;
      r_b   <= w_grant1 ? req1_b : req0_b;
      r_c   <= w_grant1 ? req1_cin : req0_cin;
      r_id  <= w_grant1;
      r_ptr <= ~w_grant1;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_cnext;
      r_sum <= (r_sum >> 1) | (W'(w_sbit) << (W - 1));
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_cout <= w_cnext;
    end
  end

  assign res_sum  = r_sum;
  assign res_cout = r_cout;
  assign res_id   = r_id;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_scheduler
// Brief    : Self-checking bench for serial_add_scheduler (W=8). Table-driven
//            adds plus hand-written backpressure, reset-abort and contention
//            sequences; results are checked against a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_scheduler;

  localparam int W = 8;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready, res_cout, res_id;
  logic [W-1:0] res_sum;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];

  serial_add_scheduler #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_cin  (req0_cin),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_cin  (req1_cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  // Scoreboard consumer: every accepted result must match the oldest entry.
  always @(negedge clk) begin
    if (reset && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual_sum=%0h required=none", res_sum);
      end else begin
        mon_e = sb.pop_front();
        check("res_id", {31'b0, res_id}, {31'b0, mon_e.id});
        check("res_sum", {24'b0, res_sum}, {24'b0, mon_e.sum});
        check("res_cout", {31'b0, res_cout}, {31'b0, mon_e.cout});
      end
    end
  end

  task automatic wait_result();
    int n;
    for (n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    if (n > 30) check("result_timeout", 32'd0, 32'd1);
  endtask

  // Drive one request, expect an immediate grant, push the expectation,
  // scramble the operands right after the handshake, then check latency.
  task automatic do_op(input vec_t v);
    int n;
    @(posedge clk); #1;
    if (v.id) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_cin = v.cin;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_cin = v.cin;
    end
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rdy(v.id)) break;
    end
    check("grant_wait", n, 32'd0);
    check("other_ready", {31'b0, rdy(~v.id)}, 32'd0);
    sb.push_back('{v.id, v.sum, v.cout});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~req0_a; req0_b = ~req0_b; req0_cin = ~req0_cin;
    req1_a = ~req1_a; req1_b = ~req1_b; req1_cin = ~req1_cin;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    check("latency", n, W + 1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{1'b1, 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{1'b1, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{1'b1, 8'h0F, 8'h01, 1'b1, 8'h11, 1'b0};

    reset = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_cin = 1'b0;

    // Reset: readies held low during the reset cycle, outputs cleared after.
    repeat (2) @(negedge clk);
    check("reset_ready0", {31'b0, req0_ready}, 32'd0);
    check("reset_ready1", {31'b0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_res_sum", {24'b0, res_sum}, 32'd0);
    check("rst_res_cout", {31'b0, res_cout}, 32'd0);
    check("rst_res_id", {31'b0, res_id}, 32'd0);

    // Table-driven adds, consumer always ready.
    for (int i = 0; i < 8; i++) do_op(vecs[i]);

    // Backpressure: result held, nothing accepted while both requesters wait.
    @(posedge clk); #1;
    res_ready = 1'b0;
    do_op('{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0});
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        req1_a = 8'h01; req1_b = 8'h02; req1_cin = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
      end
      @(negedge clk);
      check("bp_valid", {31'b0, res_valid}, 32'd1);
      check("bp_sum", {24'b0, res_sum}, 32'h46);
      check("bp_cout", {31'b0, res_cout}, 32'd0);
      check("bp_id", {31'b0, res_id}, 32'd0);
      check("bp_ready0", {31'b0, req0_ready}, 32'd0);
      check("bp_ready1", {31'b0, req1_ready}, 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    // Back in IDLE; pointer moved to requester 1 after the last grant to 0.
    check("held_grant1", {31'b0, req1_ready}, 32'd1);
    check("held_grant0", {31'b0, req0_ready}, 32'd0);
    sb.push_back('{1'b1, 8'h04, 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_result();

    // Reset during bit 3 of a requester-0 operation.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h01; req0_cin = 1'b0;
    @(negedge clk);
    check("abort_grant", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    req0_a = 8'h10; req0_b = 8'h20; req0_cin = 1'b0;
    req1_a = 8'hF0; req1_b = 8'h21; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("midrst_ready0", {31'b0, req0_ready}, 32'd0);
    check("midrst_ready1", {31'b0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_valid", {31'b0, res_valid}, 32'd0);
    check("abort_sum", {24'b0, res_sum}, 32'd0);
    check("abort_cout", {31'b0, res_cout}, 32'd0);
    check("abort_id", {31'b0, res_id}, 32'd0);

    // Contention with both held valid: service order 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      int n;
      for (n = 0; n < 30; n++) begin
        if (req0_ready || req1_ready) break;
        @(negedge clk);
      end
      check("rr_order", {31'b0, req1_ready}, k % 2);
      check("rr_onehot", {31'b0, req0_ready & req1_ready}, 32'd0);
      if (req1_ready) sb.push_back('{1'b1, 8'h12, 1'b1});
      else            sb.push_back('{1'b0, 8'h30, 1'b0});
      @(negedge clk);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_result();
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
